traffic_phase_timer: RTL and testbench

TRAFFIC_PHASE_TIMER -- requirements
Module: traffic_phase_timer

---
 rtl/traffic_phase_timer.sv | 167 ++++++++++++++++
 tb/tb_traffic_phase_timer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_timer.sv
// -----------------------------------------------------------------------------
// traffic_phase_timer
//
// Two-road traffic light phase sequencer driven by a 1 Hz tick strobe.
// The cycle is MAIN_G -> MAIN_Y -> SIDE_G -> SIDE_Y -> MAIN_G. Each phase loads
// its duration on entry and counts down once per tick. When the count reaches 1,
// the next tick advances to the next phase and loads the new duration, so count
// never shows 0 in normal operation. The lamp outputs and count are registered.
//
// Optional feature: define NIGHT_MODE_EN to add the `night` input and a NIGHT
// state. In NIGHT, both roads flash yellow and count reads 0.
//
// Parameters:
//   GREEN_T       main-road green duration in seconds (1..63)
//   SIDE_GREEN_T  side-road green duration in seconds (1..63)
//   YELLOW_T      yellow duration for either road in seconds (1..63)
//
// Ports:
//   clk         system clock, rising-edge active
//   rst         asynchronous active-high reset
//   tick        one-clk-wide 1 Hz strobe
//   hold        level; freezes phase and countdown while high
//   night       level; forces night flashing (only with NIGHT_MODE_EN)
//   main_light  {R,Y,G} one-hot lamp drive, main road
//   side_light  {R,Y,G} one-hot lamp drive, side road
//   count       seconds remaining in the current phase (0 in NIGHT)
// -----------------------------------------------------------------------------
module traffic_phase_timer #(
    parameter int GREEN_T      = 25,
    parameter int SIDE_GREEN_T = 15,
    parameter int YELLOW_T     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       hold,
`ifdef NIGHT_MODE_EN
    input  logic       night,
`endif
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [5:0] count
);

    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

    typedef enum logic [2:0] {
        MAIN_G,
        MAIN_Y,
        SIDE_G,
        SIDE_Y
`ifdef NIGHT_MODE_EN
        , NIGHT
`endif
    } phase_t;

    phase_t     state, state_next;
    logic [5:0] count_next;
    logic [2:0] main_next, side_next;
`ifdef NIGHT_MODE_EN
    logic       blink, blink_next;
`endif

    // Returns the duration that is loaded when a phase is entered.
    function automatic logic [5:0] duration(input phase_t p);
        case (p)
            MAIN_G:  return 6'(GREEN_T);
            SIDE_G:  return 6'(SIDE_GREEN_T);
            default: return 6'(YELLOW_T);
        endcase
    endfunction

    // Returns the phase that follows p in the normal cycle.
    function automatic phase_t successor(input phase_t p);
        case (p)
            MAIN_G:  return MAIN_Y;
            MAIN_Y:  return SIDE_G;
            SIDE_G:  return SIDE_Y;
            default: return MAIN_G;
        endcase
    endfunction

    // State register. The lamp outputs are registered alongside the state,
    // so every visible output changes on the same edge as the state.
    // NOTE: sequential state uses non-blocking assignments. That way every
    // register samples the values from before the edge, whatever the order
    // of the statements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= MAIN_G;
            count      <= 6'(GREEN_T);
            main_light <= LAMP_G;
            side_light <= LAMP_R;
`ifdef NIGHT_MODE_EN
            blink      <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            count      <= count_next;
            main_light <= main_next;
            side_light <= side_next;
`ifdef NIGHT_MODE_EN
            blink      <= blink_next;
`endif
        end
    end

    // Next-state logic. A tick that arrives while hold is high is dropped,
    // not remembered, so nothing here latches a pending tick.
    // NOTE: every signal gets a default assignment first. Then no path
    // through the block leaves a value unassigned, and no latch is inferred.
    always_comb begin
        state_next = state;
        count_next = count;
`ifdef NIGHT_MODE_EN
        blink_next = blink;
        if (night) begin
            // Night overrides hold and tick. Entry always starts lamps lit.
            if (state != NIGHT) begin
                state_next = NIGHT;
                count_next = 6'd0;
                blink_next = 1'b1;
            end else if (tick) begin
                blink_next = ~blink;
            end
        end else if (state == NIGHT) begin
            state_next = MAIN_G;
            count_next = 6'(GREEN_T);
            blink_next = 1'b0;
        end else
`endif
        if (tick && !hold) begin
            if (count > 6'd1) begin
                count_next = count - 6'd1;
            end else begin
                state_next = successor(state);
                count_next = duration(successor(state));
            end
        end
    end

    // Output decode of the upcoming state. The register block captures it,
    // so the lamps carry no combinational glitches.
    always_comb begin
        main_next = LAMP_R;
        side_next = LAMP_R;
        case (state_next)
            MAIN_G: main_next = LAMP_G;
            MAIN_Y: main_next = LAMP_Y;
            SIDE_G: side_next = LAMP_G;
            SIDE_Y: side_next = LAMP_Y;
`ifdef NIGHT_MODE_EN
            NIGHT: begin
                main_next = {1'b0, blink_next, 1'b0};
                side_next = {1'b0, blink_next, 1'b0};
            end
`endif
            default: begin
                main_next = LAMP_R;
                side_next = LAMP_R;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_timer
//
// Directed, table-driven bench for traffic_phase_timer with GREEN_T=4,
// SIDE_GREEN_T=3 and YELLOW_T=2. It steps through a table of {tick, hold,
// expected count/lamps} records. Hand-written sequences cover the
// hold-at-expiry case and an asynchronous reset between clock edges. A
// per-cycle monitor checks that the two roads are never both non-red.
// -----------------------------------------------------------------------------
module tb_traffic_phase_timer;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       hold;
`ifdef NIGHT_MODE_EN
    logic       night;
`endif
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic [5:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       tick;
        logic       hold;
        logic [5:0] exp_count;
        logic [2:0] exp_main;
        logic [2:0] exp_side;
    } vec_t;

    vec_t vecs[$];

    traffic_phase_timer #(
        .GREEN_T     (4),
        .SIDE_GREEN_T(3),
        .YELLOW_T    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .hold      (hold),
`ifdef NIGHT_MODE_EN
        .night     (night),
`endif
        .main_light(main_light),
        .side_light(side_light),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] actual, input logic [5:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [5:0] c, input logic [2:0] m, input logic [2:0] s);
        check({name, ".count"}, count, c);
        check({name, ".main"}, {3'b000, main_light}, {3'b000, m});
        check({name, ".side"}, {3'b000, side_light}, {3'b000, s});
    endtask

    // Applies tick/hold for one clock edge and returns 1 time unit after it.
    task automatic cycle(input logic t, input logic h);
        tick = t;
        hold = h;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    function automatic void add(input logic t, input logic h, input logic [5:0] c,
                                input logic [2:0] m, input logic [2:0] s);
        vec_t v;
        v.tick = t; v.hold = h; v.exp_count = c; v.exp_main = m; v.exp_side = s;
        vecs.push_back(v);
    endfunction

    // The two roads must never both show a non-red lamp.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((main_light[0] | main_light[1]) && (side_light[0] | side_light[1])) begin
                errors++;
                $display("FAIL both_nonred: main=%b side=%b, required one of them red (t=%0t)",
                         main_light, side_light, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Full cycle, with idle edges that must not change anything.
        add(1,0,3,G,R); add(0,0,3,G,R); add(1,0,2,G,R); add(1,0,1,G,R);
        add(1,0,2,Y,R); add(0,0,2,Y,R); add(1,0,1,Y,R);
        add(1,0,3,R,G); add(1,0,2,R,G); add(1,0,1,R,G);
        add(1,0,2,R,Y); add(1,0,1,R,Y); add(1,0,4,G,R);
        // Run to SIDE_G count 2, hold through 3 ticks, then resume.
        add(1,0,3,G,R); add(1,0,2,G,R); add(1,0,1,G,R);
        add(1,0,2,Y,R); add(1,0,1,Y,R);
        add(1,0,3,R,G); add(1,0,2,R,G);
        add(1,1,2,R,G); add(1,1,2,R,G); add(1,1,2,R,G);
        add(0,0,2,R,G); add(1,0,1,R,G);
        // Continue to MAIN_Y count 1 for the hold-at-expiry sequence.
        add(1,0,2,R,Y); add(1,0,1,R,Y); add(1,0,4,G,R);
        add(1,0,3,G,R); add(1,0,2,G,R); add(1,0,1,G,R);
        add(1,0,2,Y,R); add(1,0,1,Y,R);

        tick = 1'b0;
        hold = 1'b0;
`ifdef NIGHT_MODE_EN
        night = 1'b0;
`endif
        rst = 1'b1;
        #1;
        check_all("reset_async", 6'd4, G, R);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_held", 6'd4, G, R);
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 0);
        check_all("after_release", 6'd4, G, R);

        foreach (vecs[i]) begin
            cycle(vecs[i].tick, vecs[i].hold);
            check_all($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_main, vecs[i].exp_side);
        end

        // Tick coincident with hold at expiry is discarded, not deferred.
        cycle(1, 1);
        check_all("hold_at_expiry", 6'd1, Y, R);
        cycle(0, 0);
        check_all("hold_dropped_no_tick", 6'd1, Y, R);
        cycle(1, 0);
        check_all("advance_after_hold", 6'd3, R, G);

        // Asynchronous reset between edges during SIDE_Y.
        cycle(1, 0);
        cycle(1, 0);
        cycle(1, 0);
        check_all("in_side_y", 6'd2, R, Y);
        #2;
        rst = 1'b1;
        #1;
        check_all("reset_mid_phase", 6'd4, G, R);
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 0);
        check_all("post_reset_idle", 6'd4, G, R);
        cycle(1, 0);
        check_all("post_reset_first_tick", 6'd3, G, R);

`ifdef NIGHT_MODE_EN
        // Night entry at MAIN_G count 3, flash on ticks, then exit.
        night = 1'b1;
        cycle(0, 0);
        check_all("night_entry", 6'd0, Y, Y);
        cycle(1, 0);
        check_all("night_t1", 6'd0, 3'b000, 3'b000);
        cycle(1, 1);
        check_all("night_t2", 6'd0, Y, Y);
        cycle(1, 0);
        check_all("night_t3", 6'd0, 3'b000, 3'b000);
        cycle(1, 0);
        check_all("night_t4", 6'd0, Y, Y);
        night = 1'b0;
        cycle(0, 0);
        check_all("night_exit", 6'd4, G, R);
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
